// File: rtl/load_run_sequencer_if.sv
// Serial-in / memory-write bus between the load/run sequencer and the
// bit receiver plus instruction/data memories.
interface load_run_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              bit_valid;
    logic              bit_in;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  bit_valid,
        input  bit_in,
        output mem_we,
        output mem_sel,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output bit_valid,
        output bit_in,
        input  mem_we,
        input  mem_sel,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/load_run_sequencer.sv
// Serial program/data loader and CPU step-enable sequencer for the
// single-cycle MIPS core; everything runs on the one system clock.
module load_run_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int DEPTH    = 64,
    parameter int STEP_DIV = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_code_load,
    input  logic                 en_data_load,
    input  logic                 en,
    load_run_sequencer_if.master bus,
    output logic                 cpu_step,
    output logic                 loading,
    output logic                 running,
    output logic                 fault,
    output logic [ADDR_W:0]      word_cnt
);
    localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [ADDR_W:0]  WORD_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD_CODE, LOAD_DATA, RUN, FAULT} state_t;

    state_t            state, state_nx;
    logic [31:0]       shift, shift_nx;
    logic [4:0]        bit_cnt, bit_cnt_nx;
    logic [DIV_W-1:0]  div, div_nx;
    logic [ADDR_W:0]   word_cnt_nx;
    logic              mem_we_nx, mem_sel_nx, cpu_step_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [31:0]       mem_wdata_nx;
    logic              both_loads, load_active;

    assign both_loads  = en_code_load & en_data_load;
    assign load_active = (state == LOAD_CODE) ? en_code_load : en_data_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            shift         <= '0;
            bit_cnt       <= '0;
            div           <= '0;
            word_cnt      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_sel   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_step      <= 1'b0;
            loading       <= 1'b0;
            running       <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state         <= state_nx;
            shift         <= shift_nx;
            bit_cnt       <= bit_cnt_nx;
            div           <= div_nx;
            word_cnt      <= word_cnt_nx;
            bus.mem_we    <= mem_we_nx;
            bus.mem_sel   <= mem_sel_nx;
            bus.mem_addr  <= mem_addr_nx;
            bus.mem_wdata <= mem_wdata_nx;
            cpu_step      <= cpu_step_nx;
            // Status flags are registered from the next state so they line up with it.
            loading       <= (state_nx == LOAD_CODE) || (state_nx == LOAD_DATA);
            running       <= (state_nx == RUN);
            fault         <= (state_nx == FAULT);
        end
    end

    always_comb begin
        state_nx     = state;
        shift_nx     = shift;
        bit_cnt_nx   = bit_cnt;
        div_nx       = div;
        word_cnt_nx  = word_cnt;
        mem_we_nx    = 1'b0;
        mem_sel_nx   = bus.mem_sel;
        mem_addr_nx  = bus.mem_addr;
        mem_wdata_nx = bus.mem_wdata;
        cpu_step_nx  = 1'b0;

        unique case (state)
            IDLE: begin
                div_nx = '0;
                if (both_loads) begin
                    state_nx = FAULT;
                end else if (en_code_load || en_data_load) begin
                    state_nx    = en_code_load ? LOAD_CODE : LOAD_DATA;
                    word_cnt_nx = '0;
                    bit_cnt_nx  = '0;
                    shift_nx    = '0;
                end else if (en) begin
                    state_nx = RUN;
                end
            end
            LOAD_CODE, LOAD_DATA: begin
                if (both_loads) begin
                    state_nx = FAULT;
                end else if (!load_active) begin
                    state_nx = IDLE;
                end else if (bus.bit_valid) begin
                    shift_nx   = {shift[30:0], bus.bit_in};
                    bit_cnt_nx = bit_cnt + 5'd1;
                    if (bit_cnt == 5'd31) begin
                        if (word_cnt < WORD_MAX) begin
                            mem_we_nx    = 1'b1;
                            mem_sel_nx   = (state == LOAD_DATA);
                            mem_addr_nx  = word_cnt[ADDR_W-1:0];
                            mem_wdata_nx = shift_nx;
                            word_cnt_nx  = word_cnt + (ADDR_W + 1)'(1);
                        end else begin
                            state_nx = FAULT;
                        end
                    end
                end
            end
            RUN: begin
                if (!en) begin
                    state_nx = IDLE;
                    div_nx   = '0;
                end else if (div == DIV_LAST) begin
                    cpu_step_nx = 1'b1;
                    div_nx      = '0;
                end else begin
                    div_nx = div + DIV_W'(1);
                end
            end
            FAULT: ;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_load_run_sequencer.sv
// Randomized and directed bench for load_run_sequencer; two instances
// (DEPTH 64 and DEPTH 4) share stimulus and are checked against a model.
module tb_load_run_sequencer;
    localparam int STEP = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, ecl = 1'b0, edl = 1'b0, en = 1'b0, bv = 1'b0, bi = 1'b0;

    load_run_sequencer_if #(.ADDR_W(6)) b64 ();
    load_run_sequencer_if #(.ADDR_W(2)) b4 ();
    assign b64.bit_valid = bv;
    assign b64.bit_in    = bi;
    assign b4.bit_valid  = bv;
    assign b4.bit_in     = bi;

    logic       step64, load64, run64, flt64;
    logic [6:0] wc64;
    logic       step4, load4, run4, flt4;
    logic [2:0] wc4;

    load_run_sequencer #(.ADDR_W(6), .DEPTH(64), .STEP_DIV(STEP)) dut64 (
        .clk(clk), .rst(rst), .en_code_load(ecl), .en_data_load(edl), .en(en),
        .bus(b64.master), .cpu_step(step64), .loading(load64), .running(run64),
        .fault(flt64), .word_cnt(wc64)
    );

    load_run_sequencer #(.ADDR_W(2), .DEPTH(4), .STEP_DIV(STEP)) dut4 (
        .clk(clk), .rst(rst), .en_code_load(ecl), .en_data_load(edl), .en(en),
        .bus(b4.master), .cpu_step(step4), .loading(load4), .running(run4),
        .fault(flt4), .word_cnt(wc4)
    );

    typedef enum {M_IDLE, M_CODE, M_DATA, M_RUN, M_FAULT} mmode_t;
    typedef struct {
        mmode_t      mode;
        int          nbits;
        logic [31:0] word;
        int          wc;
        int          runc;
        bit          we;
        bit          sel;
        int          addr;
        logic [31:0] wdata;
        bit          step;
    } mdl_t;
    typedef struct {
        bit          sel;
        int          addr;
        logic [31:0] data;
    } wr_t;

    mdl_t m0, m1;
    wr_t  wr64[$], wr4[$];
    int   checks = 0, failures = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t r;
        r.mode = M_IDLE; r.nbits = 0; r.word = '0; r.wc = 0; r.runc = 0;
        r.we = 0; r.sel = 0; r.addr = 0; r.wdata = '0; r.step = 0;
        return r;
    endfunction

    // One clock of the behavioural view: words are built arithmetically, pulses
    // fall on every STEP-th cycle counted from RUN entry.
    function automatic mdl_t mstep(mdl_t s, int depth);
        mdl_t n = s;
        n.we = 0;
        n.step = 0;
        if (rst) return mreset();
        case (s.mode)
            M_IDLE: begin
                if (ecl && edl) n.mode = M_FAULT;
                else if (ecl || edl) begin
                    n.mode = ecl ? M_CODE : M_DATA;
                    n.wc = 0; n.nbits = 0; n.word = '0;
                end else if (en) begin
                    n.mode = M_RUN; n.runc = 0;
                end
            end
            M_CODE, M_DATA: begin
                if (ecl && edl) n.mode = M_FAULT;
                else if ((s.mode == M_CODE) ? !ecl : !edl) n.mode = M_IDLE;
                else if (bv) begin
                    n.word  = 32'(s.word * 2 + 32'(bi));
                    n.nbits = s.nbits + 1;
                    if (n.nbits == 32) begin
                        n.nbits = 0;
                        if (s.wc < depth) begin
                            n.we = 1; n.sel = (s.mode == M_DATA); n.addr = s.wc;
                            n.wdata = n.word; n.wc = s.wc + 1;
                        end else n.mode = M_FAULT;
                    end
                end
            end
            M_RUN: begin
                if (!en) n.mode = M_IDLE;
                else begin
                    n.runc = s.runc + 1;
                    n.step = (n.runc % STEP == 0);
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    task automatic cmp(string p, mdl_t s, logic we, logic sel, logic [5:0] addr,
                       logic [31:0] wd, logic stp, logic ld, logic rn, logic ft,
                       logic [6:0] wc);
        check({p, ".we"}, 64'(we), 64'(s.we));
        check({p, ".sel"}, 64'(sel), 64'(s.sel));
        check({p, ".addr"}, 64'(addr), 64'(s.addr));
        check({p, ".wdata"}, 64'(wd), 64'(s.wdata));
        check({p, ".step"}, 64'(stp), 64'(s.step));
        check({p, ".loading"}, 64'(ld), 64'(s.mode == M_CODE || s.mode == M_DATA));
        check({p, ".running"}, 64'(rn), 64'(s.mode == M_RUN));
        check({p, ".fault"}, 64'(ft), 64'(s.mode == M_FAULT));
        check({p, ".word_cnt"}, 64'(wc), 64'(s.wc));
    endtask

    task automatic tick();
        @(posedge clk);
        m0 = mstep(m0, 64);
        m1 = mstep(m1, 4);
        #1;
        cmp("d64", m0, b64.mem_we, b64.mem_sel, b64.mem_addr, b64.mem_wdata,
            step64, load64, run64, flt64, wc64);
        cmp("d4", m1, b4.mem_we, b4.mem_sel, 6'(b4.mem_addr), b4.mem_wdata,
            step4, load4, run4, flt4, 7'(wc4));
        if (b64.mem_we) wr64.push_back('{b64.mem_sel, int'(b64.mem_addr), b64.mem_wdata});
        if (b4.mem_we)  wr4.push_back('{b4.mem_sel, int'(b4.mem_addr), b4.mem_wdata});
    endtask

    task automatic send_word(logic [31:0] w, int gap);
        for (int i = 31; i >= 0; i--) begin
            bv = 1'b1; bi = w[i]; tick();
            bv = 1'b0; bi = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ecl = 1'b0; edl = 1'b0; en = 1'b0; bv = 1'b0; bi = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    int   op, nw, gap, nb;
    logic d;

    initial begin
        m0 = mreset();
        m1 = mreset();

        // Reset with random inputs, then release.
        for (int i = 0; i < 3; i++) begin
            {ecl, edl, en, bv, bi} = 5'($urandom);
            tick();
            check("rst_quiet", {57'd0, flt64, load64, run64, b64.mem_we, step64, |wc64, |b64.mem_wdata}, '0);
        end
        rst = 1'b0; {ecl, edl, en, bv, bi} = '0;
        tick();
        check("rst_release", {59'd0, flt64, load64, run64, b64.mem_we, step64}, '0);

        // Two instruction words, strobes three cycles apart.
        ecl = 1'b1; tick();
        wr64.delete();
        send_word(32'h2008_0005, 2);
        send_word(32'h8C09_0000, 2);
        check("t2_nwr", wr64.size(), 2);
        if (wr64.size() >= 2) begin
            check("t2_sel0", wr64[0].sel, 0);
            check("t2_addr0", wr64[0].addr, 0);
            check("t2_data0", wr64[0].data, 64'h2008_0005);
            check("t2_sel1", wr64[1].sel, 0);
            check("t2_addr1", wr64[1].addr, 1);
            check("t2_data1", wr64[1].data, 64'h8C09_0000);
        end
        check("t2_wcnt", wc64, 2);
        ecl = 1'b0; tick();

        // Partial data word aborted, then a full one.
        edl = 1'b1; tick();
        wr64.delete();
        for (int i = 0; i < 10; i++) begin
            bv = 1'b1; bi = 1'(i); tick();
            bv = 1'b0; tick();
        end
        edl = 1'b0; tick(); tick();
        check("t3_nowr", wr64.size(), 0);
        check("t3_idle", {load64, run64, flt64}, 0);
        check("t3_wcnt", wc64, 0);
        edl = 1'b1; tick();
        send_word(32'h0000_000A, 1);
        check("t3_nwr", wr64.size(), 1);
        if (wr64.size() >= 1) begin
            check("t3_sel", wr64[0].sel, 1);
            check("t3_addr", wr64[0].addr, 0);
            check("t3_data", wr64[0].data, 64'hA);
        end
        edl = 1'b0; tick();

        // Fault entry from IDLE and from LOAD_DATA; sticky until reset.
        ecl = 1'b1; edl = 1'b1; tick();
        check("t4_fault_idle", flt64, 1);
        ecl = 1'b0; edl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en = ~en; tick();
            check("t4_sticky", {flt64, run64, step64}, 3'b100);
        end
        do_reset();
        tick();
        check("t4_cleared", flt64, 0);
        edl = 1'b1; tick();
        ecl = 1'b1; tick();
        check("t4_fault_load", flt64, 1);
        do_reset();

        // Overflow on the DEPTH-4 instance.
        ecl = 1'b1; tick();
        wr4.delete(); wr64.delete();
        for (int w = 0; w < 5; w++) send_word($urandom(), 0);
        check("t5_nwr4", wr4.size(), 4);
        for (int i = 0; i < wr4.size(); i++) check("t5_addr", wr4[i].addr, i);
        check("t5_fault4", flt4, 1);
        check("t5_nwr64", wr64.size(), 5);
        do_reset();

        // Run sequencing; strobes are ignored, exit suppresses the 15th-cycle pulse.
        en = 1'b1; tick();
        wr64.delete();
        for (int k = 1; k <= 14; k++) begin
            bv = 1'($urandom); bi = 1'($urandom);
            tick();
            check("t6_step", step64, (k % STEP == 0));
        end
        en = 1'b0; bv = 1'b0; tick();
        check("t6_exit_step", step64, 0);
        check("t6_exit_run", run64, 0);
        check("t6_nowr", wr64.size(), 0);

        // Randomized phases against the model.
        for (int it = 0; it < 60; it++) begin
            if (m0.mode == M_FAULT || m1.mode == M_FAULT) do_reset();
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    {ecl, edl, en, bv} = '0;
                    repeat ($urandom_range(1, 4)) tick();
                end
                1: begin
                    d = 1'($urandom); ecl = ~d; edl = d; en = 1'($urandom);
                    tick();
                    nw = $urandom_range(1, 5);
                    gap = $urandom_range(0, 2);
                    for (int w = 0; w < nw; w++) send_word($urandom(), gap);
                    nb = $urandom_range(0, 20);
                    for (int i = 0; i < nb; i++) begin
                        bv = 1'b1; bi = 1'($urandom); tick();
                    end
                    bv = 1'b0; ecl = 1'b0; edl = 1'b0; tick();
                end
                2: begin
                    {ecl, edl} = '0; en = 1'b1;
                    repeat ($urandom_range(3, 25)) begin
                        bv = 1'($urandom); bi = 1'($urandom); tick();
                    end
                    en = 1'b0; bv = 1'b0; tick();
                end
                3: do_reset();
                default: begin
                    repeat ($urandom_range(1, 6)) begin
                        {ecl, edl, en, bv, bi} = 5'($urandom); tick();
                    end
                    {ecl, edl, en, bv, bi} = '0; tick();
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
